// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   arb_state_t - arbiter FSM states (idle / locked to one requester)
//   BYTE_W      - width of one UART payload byte
//   idx_w(n)    - width of an index selecting one of n requesters
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of req searching upward from ptr+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req - request vector, one bit per requester
//   ptr - index of the most recently served requester (lowest priority this round)
//   any - at least one request bit is set
//   idx - index of the winning requester (0 when any=0)
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int cand;

    // Walk the offsets from farthest to nearest so the nearest set bit after
    // ptr overwrites any earlier hit; offset N lands back on ptr itself, which
    // therefore only wins when it is the sole requester.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte streams, round-robin with message lock.
// Latency: 1 cycle to arbitrate from IDLE, then zero-latency pass-through while locked.
// Backpressure: tx_ready is forwarded only to the locked requester; all others see ready=0.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   req_valid    - per-requester byte valid
//   req_data     - per-requester byte, requester i in bits [8i+7:8i]
//   req_last     - byte closes the requester's message
//   req_ready    - per-requester accept (only the locked requester can see 1)
//   tx_valid/tx_data/tx_ready - handshake towards uart_tx
//   grant_idx    - locked requester index, meaningful while busy
//   busy         - a requester currently owns the transmitter
//   timeout_evt  - one-cycle pulse when a stalled lock is revoked
//                  (present only when UART_ARB_TIMEOUT_EN is defined)
//
// Build option: define UART_ARB_TIMEOUT_EN to revoke a lock after TIMEOUT_CYCLES
// consecutive locked cycles without a valid byte from the owner.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [idx_w(NUM_REQ)-1:0] grant_idx,
    output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_evt
`endif
);

    localparam int IW = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_q, grant_d;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;

    logic [BYTE_W-1:0] req_bytes [NUM_REQ];
    logic              own_vld;
    logic              xfer;
    logic              release_lock;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
    end

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Owner's byte is on the wire; a handshake here is a real transfer.
    assign own_vld = (state_q == ARB_LOCKED) && req_valid[grant_q];
    assign xfer    = own_vld && tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q;
    logic          to_hit;

    // Fires on the TIMEOUT_CYCLES-th consecutive locked cycle with the owner idle.
    assign to_hit = (state_q == ARB_LOCKED) && !req_valid[grant_q] &&
                    (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_evt = to_hit;

    // Idle cycles are never counted in ARB_IDLE, so holding the counter at
    // zero there is the same as clearing it on entry to ARB_LOCKED.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q != ARB_LOCKED || xfer || to_hit) begin
            to_cnt_q <= '0;
        end else if (!req_valid[grant_q]) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign release_lock = (xfer && req_last[grant_q]) || to_hit;
`else
    assign release_lock = xfer && req_last[grant_q];
`endif

    // Next-state and pass-through outputs. Nothing is driven towards uart_tx
    // outside ARB_LOCKED, so the cycle after a release is always a gap.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        busy      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                busy               = 1'b1;
                tx_valid           = own_vld;
                tx_data            = req_bytes[grant_q];
                req_ready[grant_q] = tx_ready;
                // Served requester drops to lowest priority for the next round.
                if (release_lock) begin
                    rr_ptr_d = grant_q;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    assign grant_idx = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a scoreboard
// holds the expected (requester, byte) order at the uart_tx side.
// Runs with default parameters and the timeout option disabled.
module tb_uart_tx_arbiter;

    localparam int NUM = 4;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] dat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NUM-1:0]   req_valid = '0;
    logic [8*NUM-1:0] req_data  = '0;
    logic [NUM-1:0]   req_last  = '0;
    logic [NUM-1:0]   req_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready = 1'b1;
    logic [1:0]       grant_idx;
    logic             busy;

    logic [8:0] src_q [NUM][$];   // {last, data} per requester
    exp_t       sb_q[$];

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic put(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    task automatic expect_b(input int r, input logic [7:0] d);
        exp_t e;
        e.idx = 2'(r);
        e.dat = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_src(input int r, input int n, input string nm);
        int c = 0;
        while (src_q[r].size() != n && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(nm, src_q[r].size(), n);
    endtask

    task automatic wait_drain(input string nm);
        int c = 0;
        while ((sb_q.size() != 0 || busy) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk(nm, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b1; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester models: retire the head byte on a handshake, present the next one.
    always @(posedge clk) begin
        logic [NUM-1:0] hs;
        hs = rst ? '0 : (req_valid & req_ready);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*8 +: 8]   = src_q[i][0][7:0];
                req_last[i]          = src_q[i][0][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*8 +: 8]   = 8'h00;
                req_last[i]          = 1'b0;
            end
        end
    end

    // Monitor: every byte accepted by uart_tx must be the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_tx_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("tx_data_order", {24'h0, tx_data}, {24'h0, e.dat});
                chk("tx_grant_idx", {30'h0, grant_idx}, {30'h0, e.idx});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single two-byte message from req0
        @(negedge clk);
        put(0, 8'h55, 1'b0); put(0, 8'hAA, 1'b1);
        expect_b(0, 8'h55); expect_b(0, 8'hAA);
        @(negedge clk);
        chk("single_arb_cycle_busy", busy, 0);
        @(negedge clk);
        chk("single_locked_busy", busy, 1);
        chk("single_grant_idx", grant_idx, 0);
        @(negedge clk);
        chk("single_second_byte", tx_data, 8'hAA);
        @(negedge clk);
        chk("single_busy_drop", busy, 0);
        chk("single_idle_tx_valid", tx_valid, 0);
        wait_drain("single_drain");

        // Round-robin over all four requesters, then wrap from ptr=3
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NUM; i++) put(i, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < NUM; i++) expect_b(i, 8'h10 + 8'(i));
        wait_drain("rr_first_round");
        @(negedge clk);
        put(2, 8'h22, 1'b1); put(0, 8'h20, 1'b1);
        expect_b(0, 8'h20); expect_b(2, 8'h22);
        wait_drain("rr_wrap");

        // No interleave: req2 arrives while req1's message is in flight
        @(negedge clk);
        put(1, 8'h41, 1'b0); put(1, 8'h42, 1'b0); put(1, 8'h43, 1'b1);
        expect_b(1, 8'h41); expect_b(1, 8'h42); expect_b(1, 8'h43); expect_b(2, 8'h99);
        wait_src(1, 2, "nointl_first_byte");
        put(2, 8'h99, 1'b1);
        errs = 0;
        for (int c = 0; c < 50 && src_q[1].size() > 0; c++) begin
            @(negedge clk);
            if (req_ready[2] !== 1'b0) errs++;
        end
        chk("nointl_ready2_low", errs, 0);
        chk("nointl_msg_done", src_q[1].size(), 0);
        wait_drain("nointl_drain");

        // Gap inside a message: lock on req3 holds, req0 waits
        do_reset();
        @(negedge clk);
        put(3, 8'h01, 1'b0);
        expect_b(3, 8'h01); expect_b(3, 8'h02); expect_b(0, 8'h77);
        wait_src(3, 0, "gap_first_byte");
        put(0, 8'h77, 1'b1);
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || grant_idx !== 2'd3 || req_ready[0] !== 1'b0 || tx_valid !== 1'b0)
                errs++;
        end
        chk("gap_lock_held", errs, 0);
        put(3, 8'h02, 1'b1);
        wait_drain("gap_drain");

        // Reset in the middle of req0's message
        do_reset();
        @(negedge clk);
        put(0, 8'h31, 1'b0);
        expect_b(0, 8'h31);
        wait_src(0, 0, "rstmid_first_byte");
        chk("rstmid_locked_before", busy, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tx_valid", tx_valid, 0);
        chk("rstmid_req_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        put(2, 8'h22, 1'b1); put(1, 8'h11, 1'b1);
        expect_b(1, 8'h11); expect_b(2, 8'h22);
        wait_drain("rstmid_lowest_first");

        // Backpressure: tx_ready low for 50 cycles with req2 locked
        @(posedge clk); #1 tx_ready = 1'b0;
        @(negedge clk);
        put(2, 8'h5A, 1'b1);
        expect_b(2, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        chk("bp_locked", busy, 1);
        errs = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || req_ready[2] !== 1'b0 || tx_data !== 8'h5A) errs++;
        end
        chk("bp_hold_stable", errs, 0);
        chk("bp_not_taken", src_q[2].size(), 1);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_passthru", req_ready[2], 1);
        @(negedge clk);
        chk("bp_transfer_first_ready", busy, 0);
        chk("bp_src_consumed", src_q[2].size(), 0);
        wait_drain("bp_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-stream requesters using round-robin arbitration with message lock.
- A granted requester keeps the transmitter until it transfers a byte flagged last, so multi-byte messages are never interleaved.
- Sits between client logic (status reporters, debug dumpers) and uart_tx's tx_valid/tx_data/tx_ready port.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 1024, idle-valid cycles before a locked grant is revoked; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of a message.
- req_ready  out  NUM_REQ  per-requester accept.
- tx_valid  out  1  to uart_tx tx_valid.
- tx_data  out  8  to uart_tx tx_data.
- tx_ready  in  1  from uart_tx tx_ready.
- grant_idx  out  $clog2(NUM_REQ)  index of the locked requester; valid while busy.
- busy  out  1  a grant is locked.

Behaviour:
- Reset: state IDLE; rr_ptr = NUM_REQ-1, so requester 0 has top priority first. Outputs: busy=0, grant_idx=0, tx_valid=0, tx_data=0, req_ready=0.
- State IDLE:
  - busy=0, tx_valid=0, all req_ready=0.
  - If any req_valid is set, pick the first asserted index searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Register the pick into grant_idx and go to LOCKED. The arbitration decision costs exactly 1 cycle.
- State LOCKED (busy=1), combinational pass-through with zero added latency:
  - tx_valid = req_valid[grant_idx].
  - tx_data = req_data slice [grant_idx].
  - req_ready[grant_idx] = tx_ready; all other req_ready = 0.
- Transfer: a byte transfers when tx_valid && tx_ready in LOCKED.
  - If the transferring byte has req_last[grant_idx]=1: rr_ptr <= grant_idx, state <= IDLE.
  - Otherwise stay LOCKED.
- Non-granted requesters are never acknowledged. Their valid, data and last are ignored until they win.
- The lock is held while the granted requester's valid is low (gaps inside a message are legal).
- A single-byte message is one byte with last=1 on its only transfer.
- No same-cycle re-arbitration: after a last transfer there is always one IDLE cycle with tx_valid=0. uart_tx is busy for 10 bit times after accepting, so throughput is unaffected.
- Requesters must hold valid, data and last stable until ready. The arbiter does not check this.
- tx_ready is honoured exactly as given; the arbiter never asserts tx_valid outside LOCKED.
- Reset asserted mid-message: return to reset state next cycle. Any partial message is abandoned; uart_tx is reset by the same rst.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to LOCKED and on every transfer.
  - It increments each LOCKED cycle in which req_valid[grant_idx]=0.
  - At TIMEOUT_CYCLES it forces rr_ptr <= grant_idx and state <= IDLE.
  - It also pulses a 1-cycle output port timeout_evt. The port exists only when the macro is defined.
- Undefined: no counter and no port; the lock is released only by a last transfer or by rst.

Decomposition:
- Package uart_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
  - Localparam BYTE_W = 8.
  - Function idx_w(n) returning $clog2(n).
- One sub-module, uart_rr_pick:
  - Purely combinational round-robin priority picker.
  - Inputs: req vector, ptr. Outputs: any, idx.
  - Reusable by later UART RX-side arbiters.

Test Plan:
- Single message: after reset, req0 sends {0x55 last=0, 0xAA last=1}.
  - Expect grant_idx=0 one cycle after valid.
  - txd must show the 0x55 frame, then the 0xAA frame.
  - busy drops the cycle after the 0xAA handshake.
- Round-robin order: req0..req3 all hold a 1-byte message (0x10..0x13, last=1) from the same cycle.
  - Expect grant order 0,1,2,3, one byte each.
  - Then re-raise req0 and req2: expect grant 0 (ptr=3 wraps to 0), then 2.
- No interleave: req1 sends a 3-byte message 0x41,0x42,0x43 while req2 asserts 0x99 at the second byte.
  - Expect the uart_tx input sequence 0x41,0x42,0x43,0x99.
  - req_ready[2] must stay 0 until 0x43 completes.
- Gap inside message: req3 sends 0x01, drops valid for 200 cycles, then sends 0x02 last=1.
  - Expect the lock held throughout (busy=1, grant_idx=3) and no other grant.
  - With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: expect timeout_evt at gap cycle 100, then IDLE.
- Reset mid-message: assert rst for 2 cycles after req0's first byte of 2.
  - Expect busy=0, tx_valid=0 and req_ready=0 the cycle after rst is sampled.
  - After release, the next grant goes to the lowest valid index.
- Backpressure: hold tx_ready=0 externally for 50 cycles with req2 valid.
  - Expect tx_valid=1, req_ready[2]=0 and tx_data stable.
  - The transfer occurs on the first tx_ready=1 cycle.
